// File: rtl/rbu_pkg.sv
// Shared types and helpers for the register bank unit and its pair incrementer.
package rbu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      INC_LO = 2'd1,
      INC_HI = 2'd2,
      DONE   = 2'd3
   } inc_state_t;

   localparam int MAX_SEL_W = 64;

   function automatic int pair_base(input int num_regs, input int num_pairs);
      return num_regs - 2 * num_pairs;
   endfunction

   // Lowest set bit of a select vector; 0 when nothing is set (callers gate with the OR).
   function automatic int lowest_set(input logic [MAX_SEL_W-1:0] vec);
      int idx;
      idx = 0;
      for (int i = MAX_SEL_W - 1; i >= 0; i--) begin
         if (vec[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rbu_pair_incrementer.sv
// Byte-serial 16-bit pair increment: low byte first, then high byte plus the latched carry.
module rbu_pair_incrementer
   import rbu_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int NUM_PAIRS = 2,
   parameter int IDX_W     = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [IDX_W-1:0]    idx_i,
   input  logic [2*DATA_W-1:0] pair_val_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                carry_o,
   output logic [IDX_W-1:0]    idx_o,
   output logic                wr_lo_o,
   output logic                wr_hi_o,
   output logic [DATA_W-1:0]   wr_byte_o
);

   inc_state_t       state_q;
   logic [IDX_W-1:0] idx_q;
   logic             lo_carry_q;
   logic             busy_q;
   logic             done_q;
   logic             carry_q;
   logic             idx_ok_s;

   assign idx_ok_s = (int'(idx_i) < NUM_PAIRS);

   // Sequencer with registered busy/done/carry; out-of-range indices never leave IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         lo_carry_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         carry_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i && idx_ok_s) begin
                  idx_q   <= idx_i;
                  busy_q  <= 1'b1;
                  carry_q <= 1'b0;
                  state_q <= INC_LO;
               end
            end
            INC_LO: begin
               lo_carry_q <= &pair_val_i[DATA_W-1:0];
               state_q    <= INC_HI;
            end
            INC_HI: begin
               carry_q <= lo_carry_q & (&pair_val_i[2*DATA_W-1:DATA_W]);
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Byte write strobes and the value to write for the current step.
   always_comb begin
      wr_lo_o   = 1'b0;
      wr_hi_o   = 1'b0;
      wr_byte_o = '0;
      case (state_q)
         INC_LO: begin
            wr_lo_o   = 1'b1;
            wr_byte_o = pair_val_i[DATA_W-1:0] + {{(DATA_W-1){1'b0}}, 1'b1};
         end
         INC_HI: begin
            wr_hi_o   = 1'b1;
            wr_byte_o = pair_val_i[2*DATA_W-1:DATA_W] + {{(DATA_W-1){1'b0}}, lo_carry_q};
         end
         default: begin
            wr_byte_o = '0;
         end
      endcase
   end

   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign carry_o = carry_q;
   assign idx_o   = idx_q;

endmodule

// File: rtl/register_bank_unit.sv
// General-purpose register bank with paired address registers, bus drive muxes,
// select-conflict detection and a byte-serial pair incrementer.
module register_bank_unit
   import rbu_pkg::*;
#(
   parameter int  DATA_W    = 8,
   parameter int  NUM_REGS  = 8,
   parameter int  NUM_PAIRS = 2,
   localparam int IDX_W     = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REGS-1:0]        ld_i,
   input  logic [NUM_REGS-1:0]        sel_i,
   input  logic [NUM_PAIRS-1:0]       ld_pair_i,
   input  logic [NUM_PAIRS-1:0]       sel_pair_i,
   input  logic [DATA_W-1:0]          data_in_i,
   input  logic [2*DATA_W-1:0]        addr_in_i,
   input  logic                       inc_start_i,
   input  logic [IDX_W-1:0]           inc_pair_idx_i,
   input  logic                       err_clr_i,
   output logic [DATA_W-1:0]          data_out_o,
   output logic                       data_oe_o,
   output logic [2*DATA_W-1:0]        addr_out_o,
   output logic                       addr_oe_o,
   output logic [NUM_REGS*DATA_W-1:0] regs_flat_o,
   output logic                       inc_busy_o,
   output logic                       inc_done_o,
   output logic                       inc_carry_o,
   output logic                       sel_conflict_o,
   output logic                       ld_collision_o
);

   localparam int PB = pair_base(NUM_REGS, NUM_PAIRS);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [DATA_W-1:0]   pair_byte_s [NUM_REGS];
   logic [2*DATA_W-1:0] pair_val_s [NUM_PAIRS];
   logic [NUM_REGS-1:0] pair_ld_s, target_s, busy_mask_s, inc_wr_s;
   logic [2*DATA_W-1:0] inc_pair_val_s;
   logic [IDX_W-1:0]    inc_idx_s;
   logic [DATA_W-1:0]   inc_byte_s;
   logic                inc_wr_lo_s, inc_wr_hi_s;
   logic                multi_sel_s, collide_s;
   logic                sel_conflict_q, ld_collision_q;
   int                  data_sel_s, addr_sel_s;

   // Per-register view of the pair structure: high byte sits at the even offset from PB.
   for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      assign regs_flat_o[r*DATA_W +: DATA_W] = regs_q[r];
      if (r >= PB) begin : g_pair_member
         localparam int P     = (r - PB) / 2;
         localparam bit IS_HI = ((r - PB) % 2) == 0;
         assign pair_ld_s[r]   = ld_pair_i[P];
         assign target_s[r]    = (inc_idx_s == IDX_W'(P));
         assign pair_byte_s[r] = IS_HI ? addr_in_i[2*DATA_W-1:DATA_W] : addr_in_i[DATA_W-1:0];
         assign inc_wr_s[r]    = target_s[r] & (IS_HI ? inc_wr_hi_s : inc_wr_lo_s);
      end else begin : g_plain
         assign pair_ld_s[r]   = 1'b0;
         assign target_s[r]    = 1'b0;
         assign pair_byte_s[r] = '0;
         assign inc_wr_s[r]    = 1'b0;
      end
   end

   for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
      assign pair_val_s[p] = {regs_q[PB+2*p], regs_q[PB+2*p+1]};
   end

   assign busy_mask_s = inc_busy_o ? target_s : '0;
   assign collide_s   = |((ld_i | pair_ld_s) & busy_mask_s);
   assign multi_sel_s = (|(sel_i & (sel_i - NUM_REGS'(1'b1))))
                      | (|(sel_pair_i & (sel_pair_i - NUM_PAIRS'(1'b1))));

   // Current value of the pair the incrementer is working on.
   always_comb begin
      inc_pair_val_s = '0;
      for (int p = 0; p < NUM_PAIRS; p++) begin
         inc_pair_val_s = (inc_idx_s == IDX_W'(p)) ? pair_val_s[p] : inc_pair_val_s;
      end
   end

   rbu_pair_incrementer #(
      .DATA_W    (DATA_W),
      .NUM_PAIRS (NUM_PAIRS),
      .IDX_W     (IDX_W)
   ) u_inc (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (inc_start_i),
      .idx_i      (inc_pair_idx_i),
      .pair_val_i (inc_pair_val_s),
      .busy_o     (inc_busy_o),
      .done_o     (inc_done_o),
      .carry_o    (inc_carry_o),
      .idx_o      (inc_idx_s),
      .wr_lo_o    (inc_wr_lo_s),
      .wr_hi_o    (inc_wr_hi_s),
      .wr_byte_o  (inc_byte_s)
   );

   // Write priority: incrementer, then frozen busy pair, then pair load, then byte load.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         if (inc_wr_s[r])         regs_d[r] = inc_byte_s;
         else if (busy_mask_s[r]) regs_d[r] = regs_q[r];
         else if (pair_ld_s[r])   regs_d[r] = pair_byte_s[r];
         else if (ld_i[r])        regs_d[r] = data_in_i;
         else                     regs_d[r] = regs_q[r];
      end
   end

   // Drive muxes resolve multiple selects to the lowest index.
   always_comb begin
      data_sel_s = lowest_set(MAX_SEL_W'(sel_i));
      addr_sel_s = lowest_set(MAX_SEL_W'(sel_pair_i));
      data_out_o = '0;
      addr_out_o = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         data_out_o = (data_oe_o && (r == data_sel_s)) ? regs_q[r] : data_out_o;
      end
      for (int p = 0; p < NUM_PAIRS; p++) begin
         addr_out_o = (addr_oe_o && (p == addr_sel_s)) ? pair_val_s[p] : addr_out_o;
      end
   end

   assign data_oe_o = |sel_i;
   assign addr_oe_o = |sel_pair_i;

   // Register storage and sticky error flags (a new error beats err_clr).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
         sel_conflict_q <= 1'b0;
         ld_collision_q <= 1'b0;
      end else begin
         regs_q         <= regs_d;
         sel_conflict_q <= multi_sel_s ? 1'b1 : (err_clr_i ? 1'b0 : sel_conflict_q);
         ld_collision_q <= collide_s   ? 1'b1 : (err_clr_i ? 1'b0 : ld_collision_q);
      end
   end

   assign sel_conflict_o = sel_conflict_q;
   assign ld_collision_o = ld_collision_q;

endmodule

// File: doc/register_bank_unit.md
Name: register_bank_unit

Overview:
- Parametrised general-purpose register bank: NUM_REGS registers of DATA_W bits, with the top 2*NUM_PAIRS registers also grouped into 2*DATA_W address pairs (8 registers, 2 pairs gives A,B,C,D,M1,M2,X,Y with pairs M and XY).
- Loads from the data or address bus, drives one selected register or pair back onto those buses, and detects select conflicts.
- Performs a multi-cycle byte-serial pair increment, the same job as the relay INC unit.
- Sits between the sequencer control signals and the shared data/address buses.

Parameters:
- DATA_W, 8, register width in bits.
- NUM_REGS, 8, number of registers; must be even and >= 2*NUM_PAIRS.
- NUM_PAIRS, 2, number of 16-bit pairs. Pair p = {reg[PB+2p] (high), reg[PB+2p+1] (low)}, where PB = NUM_REGS-2*NUM_PAIRS.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ld  input  NUM_REGS  per-register load from data_in.
- sel  input  NUM_REGS  per-register drive onto data_out.
- ld_pair  input  NUM_PAIRS  pair load from addr_in.
- sel_pair  input  NUM_PAIRS  pair drive onto addr_out.
- data_in  input  DATA_W  data bus value.
- addr_in  input  2*DATA_W  address bus value.
- inc_start  input  1  start pair increment, single-cycle pulse.
- inc_pair_idx  input  $clog2(NUM_PAIRS) (min 1)  pair to increment.
- err_clr  input  1  clears sticky error flags.
- data_out  output  DATA_W  selected register value, 0 if none selected.
- data_oe  output  1  any sel asserted.
- addr_out  output  2*DATA_W  selected pair value, 0 if none selected.
- addr_oe  output  1  any sel_pair asserted.
- regs_flat  output  NUM_REGS*DATA_W  all registers, reg0 in the LSBs, for decoder and debug.
- inc_busy  output  1  increment in progress.
- inc_done  output  1  one-cycle pulse when the increment result is written.
- inc_carry  output  1  carry out of the last increment (wrapped), held until the next inc_start.
- sel_conflict  output  1  sticky: more than one data or address source selected.
- ld_collision  output  1  sticky: load targeted the pair being incremented.

Behaviour:
- Reset: asynchronous on rst_n low. All registers, inc_busy, inc_done, inc_carry, sel_conflict and ld_collision go to 0; FSM goes to IDLE.
- Loads are registered on the rising clk edge; the value is visible on regs_flat and the drive outputs the next cycle.
- Write priority per register: increment FSM write > ld_pair > ld. A lower-priority load in the same cycle is dropped with no error, except when it targets the busy pair (see below).
- Drive paths are combinational from register state.
  - data_out: multiple sel bits drive the lowest index; sel_conflict sets on the next edge.
  - addr_out: same rule for sel_pair.
  - data_oe and addr_oe both asserted in one cycle is legal.
- Increment FSM:
  - States: IDLE, INC_LO, INC_HI, DONE.
  - IDLE: on inc_start, latch inc_pair_idx and go to INC_LO; inc_busy goes to 1 the next cycle.
  - INC_LO: low byte <= low+1; carry latched internally.
  - INC_HI: high byte <= high+carry; inc_carry <= carry out of the high byte.
  - DONE: inc_done = 1 for one cycle, inc_busy = 0, then IDLE.
  - Latency: result visible 3 cycles after the inc_start edge; inc_done coincides with the first cycle the result is visible.
  - inc_start outside IDLE is ignored.
  - inc_pair_idx >= NUM_PAIRS is ignored; the FSM stays in IDLE.
- Wrap-around: 0xFFFF increments to 0x0000 with inc_carry = 1. 0x00FF increments to 0x0100 with inc_carry = 0.
- Loads to the pair being incremented while inc_busy (ld on either byte, or ld_pair of that pair) are dropped and set ld_collision. Loads to other registers proceed normally.
- Sticky flags: err_clr clears them. If err_clr and a new error occur in the same cycle, set wins.
- Reset mid-increment aborts the operation; the pair reads 0 after reset.

Decomposition:
- Shared package rbu_pkg holds:
  - inc_state_t enum (IDLE, INC_LO, INC_HI, DONE);
  - function pair_base(NUM_REGS, NUM_PAIRS);
  - one-hot-to-lowest-index priority function, reused for both drive muxes.
- One sub-module, rbu_pair_incrementer, holds the FSM, the latched pair index, the carry and the byte-write enables. The top level handles storage, write priority, drive muxes and flags.

Test Plan:
- Reset with all regs loaded 0xA5 -> rst_n low mid-cycle -> regs_flat = 0 immediately; data_oe = 0, addr_oe = 0.
- ld[2] with data_in = 0x3C, then sel[2] -> data_out = 0x3C, data_oe = 1. Then sel[2] and sel[5] together -> data_out = reg2, sel_conflict = 1 until err_clr.
- ld_pair[1] with addr_in = 0x12FF, inc_start on pair 1 -> inc_busy for 2 cycles; 3 cycles later reg6 = 0x13, reg7 = 0x00; inc_done pulse; inc_carry = 0.
- Pair 0 = 0xFFFF, increment -> pair reads 0x0000, inc_carry = 1; addr_out = 0x0000 when sel_pair[0].
- During a pair 1 increment: ld[7] = 0x55 and ld[0] = 0x77 -> reg7 holds the increment result, ld_collision = 1, reg0 = 0x77.
- Same-edge ld[4] = 0x11 and ld_pair[0] = 0xABCD -> reg4 = 0xAB, reg5 = 0xCD. inc_start while busy -> ignored, only one inc_done.
